// File: rtl/ov7670_capture_win.sv
// OV7670 capture front end: pairs camera bytes into RGB565 pixels, optionally
// decimates by 2, writes stored pixels to a frame-buffer write port and
// reports per-frame completion and error status. Runs entirely in pclk.
module ov7670_capture_win #(
  parameter int IMG_W      = 320,
  parameter int IMG_H      = 240,
  parameter int DECIM      = 1,
  parameter int SWAP_BYTES = 0,
  parameter int ADDR_W     = 19,
  parameter int ADDR_STEP  = 4,
  parameter int DOUT_W     = 32
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic [DOUT_W-1:0] dout,
  output logic              we,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [7:0]        frame_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [11:0]       IMG_W_L  = 12'(IMG_W);
  localparam logic [11:0]       IMG_H_L  = 12'(IMG_H);
  localparam logic [ADDR_W-1:0] PIX_TOT  = ADDR_W'(IMG_W * IMG_H);
  localparam logic [ADDR_W-1:0] STEP_L   = ADDR_W'(ADDR_STEP);

  state_t state_q, state_d;

  logic              vsync_q, vsync_d, vsync_p_q, vsync_p_d;
  logic              href_q, href_d, href_p_q, href_p_d;
  logic [7:0]        d_q, d_d;
  logic              ph_q, ph_d;
  logic [7:0]        b0_q, b0_d;
  logic [11:0]       x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0] idx_q, idx_d, baddr_q, baddr_d, paddr_q, paddr_d;
  logic              long_q, long_d, odd_q, odd_d, pend_q, pend_d;
  logic [15:0]       pix_q, pix_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DOUT_W-1:0] dout_q, dout_d;
  logic              we_q, we_d, busy_q, busy_d;
  logic              done_q, done_d, err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;

  logic        vs_fall_s, vs_rise_s, href_fall_s, start_s, in_cap_s;
  logic        keep_s, fit_s;
  logic [11:0] xd_s, yd_s;
  logic [15:0] pair_s;

  assign vs_fall_s   = vsync_p_q & ~vsync_q;
  assign vs_rise_s   = vsync_q & ~vsync_p_q;
  assign href_fall_s = href_p_q & ~href_q;
  assign start_s     = (state_q == SYNC) & vs_fall_s & en;
  assign in_cap_s    = (state_q == CAPTURE);
  assign xd_s        = (DECIM == 2) ? {1'b0, x_q[11:1]} : x_q;
  assign yd_s        = (DECIM == 2) ? {1'b0, y_q[11:1]} : y_q;
  assign keep_s      = (DECIM == 1) ? 1'b1 : (~x_q[0] & ~y_q[0]);
  assign fit_s       = (xd_s < IMG_W_L) & (yd_s < IMG_H_L);
  assign pair_s      = (SWAP_BYTES == 1) ? {d_q, b0_q} : {b0_q, d_q};

  // State register.
  always_ff @(posedge pclk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: frame-aligned start, finish on vsync rise.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (vsync_q) state_d = SYNC; else state_d = IDLE;
      SYNC:    if (vs_fall_s) state_d = en ? CAPTURE : IDLE; else state_d = SYNC;
      CAPTURE: if (vs_rise_s) state_d = DONE; else state_d = CAPTURE;
      DONE:    state_d = SYNC;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs derived from the current state, registered below.
  always_comb begin
    busy_d = (state_q == CAPTURE);
    done_d = (state_q == DONE);
    if (state_q == DONE) begin
      err_d = (idx_q != PIX_TOT) | long_q | odd_q;
      cnt_d = cnt_q + 8'd1;
    end else begin
      err_d = 1'b0;
      cnt_d = cnt_q;
    end
  end

  // Input sampling, byte pairing, counters, store decision and write stage.
  always_comb begin
    vsync_d   = vsync;
    vsync_p_d = vsync_q;
    href_d    = href;
    href_p_d  = href_q;
    d_d       = d;
    ph_d      = ph_q;
    b0_d      = b0_q;
    x_d       = x_q;
    y_d       = y_q;
    idx_d     = idx_q;
    baddr_d   = baddr_q;
    paddr_d   = paddr_q;
    long_d    = long_q;
    odd_d     = odd_q;
    pend_d    = 1'b0;
    pix_d     = pix_q;
    if (start_s) begin
      ph_d    = 1'b0;
      x_d     = 12'd0;
      y_d     = 12'd0;
      idx_d   = '0;
      baddr_d = '0;
      long_d  = 1'b0;
      odd_d   = 1'b0;
    end else if (href_q) begin
      if (!ph_q) begin
        b0_d = d_q;
        ph_d = 1'b1;
      end else begin
        ph_d = 1'b0;
        x_d  = x_q + 12'd1;
        if (in_cap_s && keep_s && fit_s) begin
          pend_d  = 1'b1;
          pix_d   = pair_s;
          paddr_d = baddr_q;
          idx_d   = idx_q + ADDR_W'(1);
          baddr_d = baddr_q + STEP_L;
        end else if (in_cap_s && keep_s) begin
          long_d = 1'b1;
        end else begin
          long_d = long_q;
        end
      end
    end else begin
      ph_d = 1'b0;
      if (href_fall_s) begin
        x_d = 12'd0;
        y_d = y_q + 12'd1;
        if (ph_q && in_cap_s) odd_d = 1'b1;
        else                  odd_d = odd_q;
      end else begin
        x_d = x_q;
      end
    end
    // Write stage: one strobe per stored pixel, data/address held otherwise.
    we_d = pend_q;
    if (pend_q) begin
      addr_d = paddr_q;
      dout_d = DOUT_W'(pix_q);
    end else begin
      addr_d = addr_q;
      dout_d = dout_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_q <= 1'b0; vsync_p_q <= 1'b0; href_q <= 1'b0; href_p_q <= 1'b0;
      d_q <= 8'd0; ph_q <= 1'b0; b0_q <= 8'd0; x_q <= 12'd0; y_q <= 12'd0;
      idx_q <= '0; baddr_q <= '0; paddr_q <= '0; long_q <= 1'b0;
      odd_q <= 1'b0; pend_q <= 1'b0; pix_q <= 16'd0;
      addr_q <= '0; dout_q <= '0; we_q <= 1'b0; busy_q <= 1'b0;
      done_q <= 1'b0; err_q <= 1'b0; cnt_q <= 8'd0;
    end else begin
      vsync_q <= vsync_d; vsync_p_q <= vsync_p_d; href_q <= href_d;
      href_p_q <= href_p_d; d_q <= d_d; ph_q <= ph_d; b0_q <= b0_d;
      x_q <= x_d; y_q <= y_d; idx_q <= idx_d; baddr_q <= baddr_d;
      paddr_q <= paddr_d; long_q <= long_d; odd_q <= odd_d;
      pend_q <= pend_d; pix_q <= pix_d;
      addr_q <= addr_d; dout_q <= dout_d; we_q <= we_d; busy_q <= busy_d;
      done_q <= done_d; err_q <= err_d; cnt_q <= cnt_d;
    end
  end

  assign addr       = addr_q;
  assign dout       = dout_q;
  assign we         = we_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_ov7670_capture_win.sv
// Directed bench for ov7670_capture_win: three instances share one camera
// stimulus (nominal, byte-swapped, decimated) and per-frame results are
// compared against hand-computed values.
module tb_ov7670_capture_win;

  logic        pclk = 1'b0;
  logic        rst, vsync, href, en;
  logic [7:0]  d;

  logic [18:0] addr_a, addr_b, addr_c;
  logic [31:0] dout_a, dout_b, dout_c;
  logic        we_a, we_b, we_c, busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c, err_a, err_b, err_c;
  logic [7:0]  cnt_a, cnt_b, cnt_c;

  ov7670_capture_win #(.IMG_W(4), .IMG_H(2), .DECIM(1), .SWAP_BYTES(0)) u_a (
    .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .d(d), .en(en),
    .addr(addr_a), .dout(dout_a), .we(we_a), .busy(busy_a),
    .frame_done(done_a), .frame_err(err_a), .frame_cnt(cnt_a));

  ov7670_capture_win #(.IMG_W(4), .IMG_H(2), .DECIM(1), .SWAP_BYTES(1)) u_b (
    .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .d(d), .en(en),
    .addr(addr_b), .dout(dout_b), .we(we_b), .busy(busy_b),
    .frame_done(done_b), .frame_err(err_b), .frame_cnt(cnt_b));

  ov7670_capture_win #(.IMG_W(2), .IMG_H(1), .DECIM(2), .SWAP_BYTES(0)) u_c (
    .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .d(d), .en(en),
    .addr(addr_c), .dout(dout_c), .we(we_c), .busy(busy_c),
    .frame_done(done_c), .frame_err(err_c), .frame_cnt(cnt_c));

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_errors = 0;
  int bcnt;

  logic [18:0] wa_addr [0:15];
  logic [31:0] wa_dout [0:15];
  logic [18:0] wc_addr [0:3];
  logic [31:0] wc_dout [0:3];
  logic [31:0] wb_first;
  int nwa, nwb, nwc, nda, ndb, ndc;
  logic erra, errb, errc;
  logic [7:0] cnta;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Record writes and frame completions away from the active edge.
  always @(negedge pclk) begin
    if (we_a) begin
      if (nwa < 16) begin wa_addr[nwa] = addr_a; wa_dout[nwa] = dout_a; end
      nwa++;
    end
    if (we_b) begin
      if (nwb == 0) wb_first = dout_b;
      nwb++;
    end
    if (we_c) begin
      if (nwc < 4) begin wc_addr[nwc] = addr_c; wc_dout[nwc] = dout_c; end
      nwc++;
    end
    if (done_a) begin nda++; erra = err_a; cnta = cnt_a; end
    if (done_b) begin ndb++; errb = err_b; end
    if (done_c) begin ndc++; errc = err_c; end
  end

  task automatic clr();
    nwa = 0; nwb = 0; nwc = 0; nda = 0; ndb = 0; ndc = 0;
    erra = 1'bx; errb = 1'bx; errc = 1'bx; cnta = 8'hxx; wb_first = 32'hx;
  endtask

  task automatic start_frame();
    vsync = 1'b1;
    repeat (3) @(negedge pclk);
    vsync = 1'b0;
    bcnt = 1;
    repeat (4) @(negedge pclk);
  endtask

  task automatic send_line(input int n);
    for (int i = 0; i < n; i++) begin
      href = 1'b1;
      d = 8'(bcnt);
      bcnt++;
      @(negedge pclk);
    end
    href = 1'b0;
    d = 8'h00;
    repeat (4) @(negedge pclk);
  endtask

  task automatic end_frame();
    vsync = 1'b1;
    repeat (8) @(negedge pclk);
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; href = 1'b0; d = 8'h00; en = 1'b1;
    clr();
    repeat (3) @(negedge pclk);
    check("rst_addr", 32'(addr_a), 32'h0);
    check("rst_dout", dout_a, 32'h0);
    check("rst_flags", {27'h0, we_a, busy_a, done_a, err_a, 1'b0}, 32'h0);
    check("rst_cnt", 32'(cnt_a), 32'h0);
    rst = 1'b0;
    @(negedge pclk);

    // Frame 1: nominal, shared by all three instances.
    clr();
    start_frame();
    send_line(8);
    send_line(8);
    check("f1_busy", 32'(busy_a), 32'h1);
    end_frame();
    check("f1_nw", 32'(nwa), 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("f1_addr%0d", i), 32'(wa_addr[i]), 32'(i * 4));
    check("f1_dout0", wa_dout[0], 32'h0000_0102);
    check("f1_dout7", wa_dout[7], 32'h0000_0F10);
    check("f1_done", 32'(nda), 32'd1);
    check("f1_err", 32'(erra), 32'd0);
    check("f1_cnt", 32'(cnta), 32'd1);
    check("f1_busy_end", 32'(busy_a), 32'h0);
    check("swap_dout0", wb_first, 32'h0000_0201);
    check("swap_err", 32'(errb), 32'd0);
    check("dec_nw", 32'(nwc), 32'd2);
    check("dec_addr0", 32'(wc_addr[0]), 32'h0);
    check("dec_dout0", wc_dout[0], 32'h0000_0102);
    check("dec_addr1", 32'(wc_addr[1]), 32'h4);
    check("dec_dout1", wc_dout[1], 32'h0000_0506);
    check("dec_done", 32'(ndc), 32'd1);
    check("dec_err", 32'(errc), 32'd0);

    // Frame 2: 10-byte line overruns IMG_W.
    clr();
    start_frame();
    send_line(10);
    send_line(8);
    end_frame();
    check("ovr_nw", 32'(nwa), 32'd8);
    check("ovr_addr4", 32'(wa_addr[4]), 32'd16);
    check("ovr_dout4", wa_dout[4], 32'h0000_0B0C);
    check("ovr_err", 32'(erra), 32'd1);
    check("ovr_cnt", 32'(cnta), 32'd2);

    // Frame 3: 7-byte line leaves a dangling byte.
    clr();
    start_frame();
    send_line(7);
    send_line(8);
    end_frame();
    check("odd_nw", 32'(nwa), 32'd7);
    check("odd_dout2", wa_dout[2], 32'h0000_0506);
    check("odd_dout3", wa_dout[3], 32'h0000_0809);
    check("odd_addr3", 32'(wa_addr[3]), 32'd12);
    check("odd_err", 32'(erra), 32'd1);
    check("odd_cnt", 32'(cnta), 32'd3);

    // Frame 4: enable raised only after the vsync fall.
    clr();
    en = 1'b0;
    start_frame();
    en = 1'b1;
    send_line(8);
    send_line(8);
    end_frame();
    check("enmid_nw", 32'(nwa), 32'd0);
    check("enmid_done", 32'(nda), 32'd0);

    // Frame 5: enable dropped mid-capture still completes the frame.
    clr();
    start_frame();
    send_line(8);
    en = 1'b0;
    send_line(8);
    end_frame();
    check("endrop_nw", 32'(nwa), 32'd8);
    check("endrop_done", 32'(nda), 32'd1);
    check("endrop_cnt", 32'(cnta), 32'd4);

    // Frame 6: enable low at frame start, nothing captured.
    clr();
    start_frame();
    send_line(8);
    send_line(8);
    end_frame();
    check("enoff_nw", 32'(nwa), 32'd0);
    check("enoff_done", 32'(nda), 32'd0);

    // Frame 7: reset after three writes.
    clr();
    en = 1'b1;
    start_frame();
    send_line(6);
    check("rstm_nw", 32'(nwa), 32'd3);
    rst = 1'b1;
    @(negedge pclk);
    check("rstm_addr", 32'(addr_a), 32'h0);
    check("rstm_dout", dout_a, 32'h0);
    check("rstm_flags", {27'h0, we_a, busy_a, done_a, err_a, 1'b0}, 32'h0);
    check("rstm_cnt", 32'(cnt_a), 32'h0);
    rst = 1'b0;
    send_line(8);
    end_frame();
    check("rstm_post_nw", 32'(nwa), 32'd3);
    check("rstm_post_done", 32'(nda), 32'd0);

    // Frame 8: clean capture after reset.
    clr();
    start_frame();
    send_line(8);
    send_line(8);
    end_frame();
    check("after_nw", 32'(nwa), 32'd8);
    check("after_addr0", 32'(wa_addr[0]), 32'h0);
    check("after_dout0", wa_dout[0], 32'h0000_0102);
    check("after_err", 32'(erra), 32'd0);
    check("after_cnt", 32'(cnta), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
